k_regfile_bypass: RTL
=====================

# k_regfile_bypass

Parametrised register file for the datapath: two registered read ports, one write port, a configurable zero register, per-port read-enable hold for pipeline stalls, and a hardware clear sequencer that sweeps every entry to zero after reset. It sits between decode (address supply) and the ALU operand registers, and replaces the fixed 32x32 register file. It is the clean-reset, stall-aware generation of that block.

## Interface

Parameters:
- DATA_W, 32, width of each register and of all data ports
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- rs  input  ADDR_W  read port A address
- rt  input  ADDR_W  read port B address
- rs_en  input  1  1 = load port A output this edge, 0 = hold
- rt_en  input  1  1 = load port B output this edge, 0 = hold
- rd  input  ADDR_W  write address
- K_write_data  input  DATA_W  write data
- K_Regwrite  input  1  write request
- K_in1  output  DATA_W  port A read data (registered)
- K_in2  output  DATA_W  port B read data (registered)
- ready  output  1  1 = clear sweep finished, file accepts writes and returns stored data

## Operation

- States: CLEAR, IDLE. Clear counter cnt, ADDR_W bits.
- Reset (reset=1 at an edge): state<=CLEAR, cnt<=0, ready<=0, K_in1<=0, K_in2<=0. Register contents are not touched on the reset edge itself.
- CLEAR (reset=0): each edge writes registers[cnt]<=0 and increments cnt.
  - On the edge where cnt==DEPTH-1: state<=IDLE, ready<=1.
  - K_Regwrite is ignored and no write occurs.
  - K_in1 and K_in2 load 0 when their enable is 1 and hold when it is 0.
- IDLE:
  - Write: if K_Regwrite=1, registers[rd]<=K_write_data, except rd==0 with ZERO_REG=1, which is dropped.
  - Read A: if rs_en=1, K_in1<=value(rs); otherwise K_in1 holds. Port B is identical with rt, rt_en and K_in2.
  - value(a): 0 if a==0 and ZERO_REG=1; otherwise the bypassed or stored data (see Configuration).
- Both read ports may address the same entry; both return the same value.
- Reset asserted mid-sweep restarts the sweep from cnt=0.
- Reset asserted in IDLE re-enters CLEAR and wipes the file again.

## Timing

- Read latency: 1 cycle. Addresses and enables sampled at edge N; data valid after edge N.
- Write latency: 1 cycle. Data is stored at the sampling edge and visible to a read sampled at edge N+1 regardless of configuration.
- Sweep length: exactly DEPTH edges with reset=0. For DEPTH=32, ready rises after the 32nd such edge, and the first accepted write is at the 33rd.
- Reset dominates every other input at any edge.
- Same-edge write and read to the same address: behaviour is set by the macro below.

## Configuration

- Macro KRF_BYPASS_EN.
- Defined (write-first): if K_Regwrite=1, state is IDLE, the write is not dropped, and the read address equals rd at the same edge, then the enabled read port loads K_write_data.
- Undefined (read-first): the enabled read port loads the pre-write stored value; the new data appears on the next enabled read.
- Zero-register and CLEAR rules take precedence over bypass in both builds.

## Test plan

- Reset sweep: assert reset for 2 edges, release -> ready=0 for 31 edges and 1 after the 32nd; K_in1=K_in2=0 throughout; a read of every address afterwards returns 0.
- Write/read: write 0xDEADBEEF to r5, then read rs=5, rt=5 -> K_in1=K_in2=0xDEADBEEF one cycle later.
- Zero register (ZERO_REG=1): write 0x12345678 to r0, then read r0 -> 0. With ZERO_REG=0 -> 0x12345678.
- Bypass: r7 holds 0x1; same edge write 0x2 to r7 and read rs=7 -> K_in1=0x2 with KRF_BYPASS_EN, 0x1 without; a read on the next edge gives 0x2 in both builds.
- Stall hold: K_in1=0xA from r3; set rs_en=0, write r3<=0xB, change rs -> K_in1 stays 0xA until rs_en=1.
- Reset mid-sweep and write during CLEAR: pulse reset at sweep edge 10 -> ready rises 32 edges after release; K_Regwrite=1 to r4 with 0x55 during the sweep -> r4 reads 0 after ready.

Source files
------------

// File: rtl/k_regfile_bypass_if.sv
// Decode-side bus of the register file: read/write addresses, write data and registered operands.
// The master modport is the address supplier, the slave modport is the register file.
interface k_regfile_bypass_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              rs_en;
    logic              rt_en;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] K_write_data;
    logic              K_Regwrite;
    logic [DATA_W-1:0] K_in1;
    logic [DATA_W-1:0] K_in2;
    logic              ready;

    modport master (
        output rs, rt, rs_en, rt_en, rd, K_write_data, K_Regwrite,
        input  K_in1, K_in2, ready
    );

    modport slave (
        input  rs, rt, rs_en, rt_en, rd, K_write_data, K_Regwrite,
        output K_in1, K_in2, ready
    );
endinterface

// File: rtl/k_regfile_bypass.sv
// Two-read/one-write register file with stall hold and a post-reset clear sweep.
// Define KRF_BYPASS_EN for write-first same-edge forwarding; default build is read-first.
//
//   state    | meaning
//   ST_CLEAR | sweeping every entry to zero, writes ignored, reads load 0
//   ST_IDLE  | normal operation, ready=1
module k_regfile_bypass #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic               clock,
    input  logic               reset,
    k_regfile_bypass_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ready;
    logic [DATA_W-1:0] r_k_in1;
    logic [DATA_W-1:0] r_k_in2;
    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_wr_ok;
    logic              w_zero_a;
    logic              w_zero_b;
    logic              w_byp_a;
    logic              w_byp_b;
    logic [DATA_W-1:0] w_val_a;
    logic [DATA_W-1:0] w_val_b;

    assign w_zero_a = (ZERO_REG != 0) && (bus.rs == '0);
    assign w_zero_b = (ZERO_REG != 0) && (bus.rt == '0);
    assign w_wr_ok  = bus.K_Regwrite && (r_state == ST_IDLE) &&
                      !((ZERO_REG != 0) && (bus.rd == '0));

`ifdef KRF_BYPASS_EN
    assign w_byp_a = w_wr_ok && (bus.rs == bus.rd);
    assign w_byp_b = w_wr_ok && (bus.rt == bus.rd);
`else
    assign w_byp_a = 1'b0;
    assign w_byp_b = 1'b0;
`endif

    // zero register wins over forwarding
    assign w_val_a = w_zero_a ? '0 : (w_byp_a ? bus.K_write_data : r_regs[bus.rs]);
    assign w_val_b = w_zero_b ? '0 : (w_byp_b ? bus.K_write_data : r_regs[bus.rt]);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_k_in1 <= '0;
            r_k_in2 <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_regs[r_cnt] <= '0;
                    r_cnt         <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                    if (bus.rs_en) r_k_in1 <= '0;
                    if (bus.rt_en) r_k_in2 <= '0;
                end
                ST_IDLE: begin
                    if (w_wr_ok) r_regs[bus.rd] <= bus.K_write_data;
                    if (bus.rs_en) r_k_in1 <= w_val_a;
                    if (bus.rt_en) r_k_in2 <= w_val_b;
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign bus.K_in1 = r_k_in1;
    assign bus.K_in2 = r_k_in2;
    assign bus.ready = r_ready;
endmodule
